// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave register bus for pio_in_edge_irq: 2-bit address, 32-bit data,
// active-low write strobe qualified by chipselect, registered read data.
interface pio_in_edge_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pio_in_edge_irq.sv
// Parametrised input PIO with synchroniser, per-bit edge capture, irq mask and registered irq.
// Optional per-bit debounce filter after the synchroniser: define PIO_IN_DEBOUNCE_EN.
module pio_in_edge_irq #(
    parameter int               WIDTH           = 20,
    parameter int               SYNC_STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_MASK      = '0,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    pio_in_edge_irq_if.slave bus,
    input  logic [WIDTH-1:0] in_port_i,
    output logic             irq_o
);

    typedef enum logic [1:0] {
        MODE_RISE  = 2'd0,
        MODE_FALL  = 2'd1,
        MODE_ANY   = 2'd2,
        MODE_LEVEL = 2'd3
    } edgeMode_t;

    // Warm-up must outlast the whole input pipeline so inputs high at reset exit never capture.
`ifdef PIO_IN_DEBOUNCE_EN
    localparam int WARM_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int WARM_CYCLES = SYNC_STAGES + 1;
`endif
    localparam int WARM_W = $clog2(WARM_CYCLES + 1);

    logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]  syncVal;
    logic [WIDTH-1:0]  filt;
    logic [WIDTH-1:0]  prev_q;
    logic [WARM_W-1:0] warm_q;

    edgeMode_t         mode_q, mode_d;
    logic [WIDTH-1:0]  irqMask_q, irqMask_d;
    logic [WIDTH-1:0]  edgeCap_q, edgeCap_d;
    logic [31:0]       readData_q, readData_d;
    logic              irq_q, irq_d;

    logic [WIDTH-1:0]  rise;
    logic [WIDTH-1:0]  fall;
    logic [WIDTH-1:0]  det;
    logic [WIDTH-1:0]  clr;
    logic              wrEn;
    logic              enterLevel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= in_port_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign syncVal = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    logic [15:0]      dbCnt_q [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // A bit follows sync only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                dbCnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (syncVal[i] == filt_q[i]) begin
                    dbCnt_q[i] <= '0;
                end else if (dbCnt_q[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[i]  <= syncVal[i];
                    dbCnt_q[i] <= '0;
                end else begin
                    dbCnt_q[i] <= dbCnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = syncVal;
`endif

    assign rise = filt & ~prev_q;
    assign fall = ~filt & prev_q;

    always_comb begin
        det = '0;
        if (warm_q == '0) begin
            case (mode_q)
                MODE_RISE: det = rise;
                MODE_FALL: det = fall;
                MODE_ANY:  det = rise | fall;
                default:   det = '0;
            endcase
        end

        wrEn       = bus.chipselect && !bus.write_n;
        clr        = '0;
        enterLevel = 1'b0;
        mode_d     = mode_q;
        irqMask_d  = irqMask_q;

        if (wrEn) begin
            case (bus.address)
                2'd1: begin
                    mode_d     = edgeMode_t'(bus.writedata[1:0]);
                    enterLevel = (bus.writedata[1:0] == 2'd3);
                end
                2'd2:    irqMask_d = bus.writedata[WIDTH-1:0];
                2'd3:    clr       = bus.writedata[WIDTH-1:0];
                default: ;
            endcase
        end

        // Set beats clear on a colliding bit; level mode keeps the capture register empty.
        edgeCap_d = (edgeCap_q & ~clr) | det;
        if ((mode_q == MODE_LEVEL) || enterLevel) begin
            edgeCap_d = '0;
        end

        if (mode_q == MODE_LEVEL) begin
            irq_d = |(filt & irqMask_q);
        end else begin
            irq_d = |(edgeCap_q & irqMask_q);
        end

        readData_d = '0;
        case (bus.address)
            2'd0: readData_d[WIDTH-1:0] = filt;
            2'd1: readData_d[1:0]       = mode_q;
            2'd2: readData_d[WIDTH-1:0] = irqMask_q;
            2'd3: readData_d[WIDTH-1:0] = edgeCap_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            warm_q     <= WARM_W'(WARM_CYCLES);
            mode_q     <= MODE_RISE;
            irqMask_q  <= RESET_MASK;
            edgeCap_q  <= '0;
            readData_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= filt;
            if (warm_q != '0) begin
                warm_q <= warm_q - WARM_W'(1);
            end
            mode_q     <= mode_d;
            irqMask_q  <= irqMask_d;
            edgeCap_q  <= edgeCap_d;
            readData_q <= readData_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.readdata = readData_q;
    assign irq_o        = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed self-checking bench for pio_in_edge_irq (default build, WIDTH=20, SYNC_STAGES=2).
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] inPort;
    logic        irq;
    logic [31:0] rd;
    int          checkCount = 0;
    int          errorCount = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq_if bus ();

    pio_in_edge_irq #(
        .WIDTH           (20),
        .SYNC_STAGES     (2),
        .RESET_MASK      (20'h0),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .in_port_i (inPort),
        .irq_o     (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [19:0] value);
        inPort = value;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = data;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        tick();
        data = bus.readdata;
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        applyStimulus(20'hFFFFF);
        tick(3);
        checkOutput("resetReaddata", bus.readdata, 32'h0);
        checkOutput("resetIrq", {31'b0, irq}, 32'h0);

        // Inputs already high across reset release must not capture.
        reset_n = 1'b1;
        tick(10);
        checkOutput("warmIrq", {31'b0, irq}, 32'h0);
        busRead(2'd3, rd);
        checkOutput("warmCapture", rd, 32'h0);
        busRead(2'd0, rd);
        checkOutput("warmData", rd, 32'h000FFFFF);
        busRead(2'd2, rd);
        checkOutput("resetMask", rd, 32'h0);
        busRead(2'd1, rd);
        checkOutput("resetMode", rd, 32'h0);

        // Rising edge on bit0: capture set at k+2, irq at k+3.
        applyStimulus(20'h0);
        tick(5);
        busWrite(2'd2, 32'h1);
        bus.address = 2'd3;
        tick();
        checkOutput("fallIgnoredMode0", bus.readdata, 32'h0);
        applyStimulus(20'h00001);
        tick();
        checkOutput("riseIrqK", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("riseIrqK1", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("riseIrqK2", {31'b0, irq}, 32'h0);
        checkOutput("riseCapBeforeK2", bus.readdata, 32'h0);
        tick();
        checkOutput("riseIrqK3", {31'b0, irq}, 32'h1);
        checkOutput("riseCapK2", bus.readdata, 32'h1);
        busWrite(2'd3, 32'h1);
        checkOutput("clrIrqHold", {31'b0, irq}, 32'h1);
        tick();
        checkOutput("clrIrqDrop", {31'b0, irq}, 32'h0);
        checkOutput("clrCapture", bus.readdata, 32'h0);

        // Falling edge on bit5 with mask off, then unmask.
        busWrite(2'd2, 32'h0);
        busWrite(2'd1, 32'h1);
        applyStimulus(20'h00021);
        tick(5);
        busRead(2'd3, rd);
        checkOutput("riseIgnoredMode1", rd, 32'h0);
        applyStimulus(20'h00001);
        tick(5);
        busRead(2'd3, rd);
        checkOutput("fallCapture", rd, 32'h20);
        checkOutput("fallMaskedIrq", {31'b0, irq}, 32'h0);
        busWrite(2'd2, 32'h20);
        checkOutput("unmaskIrqSame", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("unmaskIrqNext", {31'b0, irq}, 32'h1);
        busWrite(2'd2, 32'h0);
        busWrite(2'd3, 32'h20);

        // Any-edge mode: clear of bit3 in the same cycle as its capture.
        busWrite(2'd1, 32'h2);
        tick(2);
        busRead(2'd3, rd);
        checkOutput("anyPreCapture", rd, 32'h0);
        applyStimulus(20'h00009);
        tick(2);
        busWrite(2'd3, 32'h8);
        busRead(2'd3, rd);
        checkOutput("collisionSetWins", rd, 32'h8);

        // Level mode: entry clears capture, irq follows masked sync.
        busWrite(2'd1, 32'h3);
        busRead(2'd3, rd);
        checkOutput("levelEntryClears", rd, 32'h0);
        busWrite(2'd2, 32'h80000);
        bus.address = 2'd3;
        tick();
        applyStimulus(20'h80009);
        tick();
        checkOutput("levelIrqK", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("levelIrqK1", {31'b0, irq}, 32'h0);
        tick();
        checkOutput("levelIrqK2", {31'b0, irq}, 32'h1);
        checkOutput("levelCapZero", bus.readdata, 32'h0);
        busRead(2'd0, rd);
        checkOutput("levelData", rd, 32'h00080009);
        applyStimulus(20'h00009);
        tick();
        checkOutput("levelDropK", {31'b0, irq}, 32'h1);
        tick();
        checkOutput("levelDropK1", {31'b0, irq}, 32'h1);
        tick();
        checkOutput("levelDropK2", {31'b0, irq}, 32'h0);
        busRead(2'd3, rd);
        checkOutput("levelCapStillZero", rd, 32'h0);

        // Asynchronous reset mid-operation while irq is high.
        applyStimulus(20'h80009);
        tick(4);
        checkOutput("preResetIrq", {31'b0, irq}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("asyncResetIrq", {31'b0, irq}, 32'h0);
        checkOutput("asyncResetReaddata", bus.readdata, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        busRead(2'd1, rd);
        checkOutput("reResetMode", rd, 32'h0);
        busRead(2'd2, rd);
        checkOutput("reResetMask", rd, 32'h0);
        busRead(2'd3, rd);
        checkOutput("reWarmCapture", rd, 32'h0);

        // Capture bits survive a change between edge modes.
        applyStimulus(20'h80019);
        tick(4);
        busWrite(2'd1, 32'h1);
        tick(2);
        busRead(2'd3, rd);
        checkOutput("modeChangeRetain", rd, 32'h10);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM slave input port: successor to the fixed 20-bit read-only PIO.
- Input synchroniser, per-bit edge detection with selectable mode, sticky edge-capture register, interrupt mask and registered IRQ output.
- Sits between board-level inputs (keys, switches, status lines) and the Nios system interconnect; one instance per input group.

Parameters:
- WIDTH, 20, number of input bits (1..32).
- SYNC_STAGES, 2, synchroniser flop stages on in_port (2..4).
- RESET_MASK, 0, reset value of the irqmask register (WIDTH bits).
- DEBOUNCE_CYCLES, 16, stable-cycle count, used only with PIO_IN_DEBOUNCE_EN (1..65535).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe (valid with chipselect).
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  registered level interrupt, active high.

Behaviour:
- Reset is reset_n, asynchronous, active-low; clock is clk. All registers reset: readdata=0, irq=0, mode=0, irqmask=RESET_MASK, edgecapture=0, sync chain=0, prev=0.
- Register map, unused upper bits read 0:
  - addr 0 data: RO, synchronised (filtered) input.
  - addr 1 mode: RW, bits[1:0]. 0=rising, 1=falling, 2=any edge, 3=level.
  - addr 2 irqmask: RW, WIDTH bits.
  - addr 3 edgecapture: read / write-1-to-clear.
- Writes to addr 0 are ignored.
- Read path: readdata <= mux(address) every clk regardless of chipselect; read latency 1 cycle.
- Write: when chipselect=1 and write_n=0, the target register updates at that clk edge.
- Synchroniser: sync = in_port delayed SYNC_STAGES flops; prev <= sync each cycle.
- Edge detect: rise=sync&~prev, fall=~sync&prev. Selected per mode.
- Warm-up: a down-counter loaded to SYNC_STAGES+1 at reset gates edge detection until it reaches 0. An input already high at reset exit sets no capture bit.
- edgecapture[i] <= (edgecapture[i] & ~clr[i]) | det[i]. clr[i] = writedata[i] on an addr-3 write.
- Simultaneous edge and clear on the same bit: set wins.
- Mode 3 (level): edgecapture is held at 0 and cleared on entry.
- irq: registered one cycle.
  - modes 0-2: irq <= |(edgecapture & irqmask).
  - mode 3: irq <= |(sync & irqmask).
- Latency, mode 0: in_port rising sampled at edge k gives sync high at k+SYNC_STAGES-1, capture set at k+SYNC_STAGES, irq high at k+SYNC_STAGES+1.
- Mode change mid-operation: existing capture bits are retained (except entry into mode 3). Detection uses the new mode from the next cycle.
- reset_n asserted mid-operation: immediate return to reset values, including a warm-up restart.

Optional Feature:
- Macro PIO_IN_DEBOUNCE_EN.
- Defined: a per-bit 16-bit counter sits after the synchroniser. The filtered bit takes the synced value only after DEBOUNCE_CYCLES consecutive cycles of a differing, stable value; any bounce resets that bit's counter. Data register, edge detect and level irq all use the filtered value. Latency grows by DEBOUNCE_CYCLES cycles.
- Undefined: no counters; the filtered value equals sync.

Test Plan:
- Warm-up: hold in_port=0xFFFFF through reset release, wait 10 cycles -> edgecapture=0, irq=0, data read=0x000FFFFF.
- Rising irq: mode=0, irqmask=0x00001; in_port bit0 0->1 at edge k -> edgecapture=0x1 at k+2, irq=1 at k+3. Write 0x1 to addr 3 -> irq=0 two cycles later.
- Falling masked: mode=1, irqmask=0; bit5 1->0 -> edgecapture=0x20, irq stays 0. Set irqmask=0x20 -> irq=1 next cycle.
- Clear/edge collision: mode=2; a new bit3 edge lands in the same cycle as a write of 0x8 to addr 3 -> edgecapture bit3 remains 1.
- Level mode: mode=3, irqmask=0x80000, in_port[19]=1 -> irq=1 after 3 cycles. Drop input -> irq=0 after 3 cycles; edgecapture reads 0 throughout.
- PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: toggle bit0 every 5 cycles -> data bit0 never changes. Hold high for 20 cycles -> data bit0=1 after 2+16 cycles.
